// File: rtl/gpin_sync_pkg.sv
// gpin_sync_pkg: shared GPIO input constants and width helper
package gpin_sync_pkg;
    localparam int GPIO_WIDTH = 32;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILT_PRESC = 16;
    localparam int DEF_FILT_LEN = 4;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction
endpackage

// File: rtl/gpin_filt_bit.sv
// gpin_filt_bit: one pin's synchroniser, tick-driven debounce counter and sticky edge event
module gpin_filt_bit
    import gpin_sync_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_LEN = DEF_FILT_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic pin,
    input  logic rise_en,
    input  logic fall_en,
    input  logic evt_clr,
    output logic val,
    output logic evt
);
    localparam int CW = clog2(FILT_LEN);
    localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt;
    logic s, diff, upd;

    assign s = sync[SYNC_STAGES-1];
    assign diff = tick && (s != val);
    assign upd = diff && (cnt == LAST);

    // a set on the same edge as a clear wins so no edge is lost
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            cnt <= '0;
            val <= 1'b0;
            evt <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            cnt <= !tick ? cnt : (upd || !diff) ? '0 : cnt + 1'b1;
            val <= upd ? s : val;
            evt <= (upd && (s ? rise_en : fall_en)) || (evt && !evt_clr);
        end
    end
endmodule

// File: rtl/gpin_sync.sv
// gpin_sync: gathers 32 async pins into a synchronised, debounced bus with edge events and irq
module gpin_sync
    import gpin_sync_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_PRESC = DEF_FILT_PRESC,
    parameter int FILT_LEN = DEF_FILT_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic gpin0,  input logic gpin1,  input logic gpin2,  input logic gpin3,
    input  logic gpin4,  input logic gpin5,  input logic gpin6,  input logic gpin7,
    input  logic gpin8,  input logic gpin9,  input logic gpin10, input logic gpin11,
    input  logic gpin12, input logic gpin13, input logic gpin14, input logic gpin15,
    input  logic gpin16, input logic gpin17, input logic gpin18, input logic gpin19,
    input  logic gpin20, input logic gpin21, input logic gpin22, input logic gpin23,
    input  logic gpin24, input logic gpin25, input logic gpin26, input logic gpin27,
    input  logic gpin28, input logic gpin29, input logic gpin30, input logic gpin31,
    input  logic [GPIO_WIDTH-1:0] rise_en,
    input  logic [GPIO_WIDTH-1:0] fall_en,
    input  logic [GPIO_WIDTH-1:0] evt_clr,
    output logic [GPIO_WIDTH-1:0] gpin,
    output logic [GPIO_WIDTH-1:0] evt,
    output logic irq
);
    localparam int PW = clog2(FILT_PRESC);
    localparam logic [PW-1:0] PLAST = PW'(FILT_PRESC - 1);

    logic [PW-1:0] presc;
    logic tick;
    logic [GPIO_WIDTH-1:0] pins;

    assign pins = {gpin31, gpin30, gpin29, gpin28, gpin27, gpin26, gpin25, gpin24,
                   gpin23, gpin22, gpin21, gpin20, gpin19, gpin18, gpin17, gpin16,
                   gpin15, gpin14, gpin13, gpin12, gpin11, gpin10, gpin9,  gpin8,
                   gpin7,  gpin6,  gpin5,  gpin4,  gpin3,  gpin2,  gpin1,  gpin0};
    assign tick = presc == PLAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            irq <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            irq <= |evt;
        end
    end

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_bit
        gpin_filt_bit #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_bit (
            .clk(clk), .rst(rst), .tick(tick), .pin(pins[i]),
            .rise_en(rise_en[i]), .fall_en(fall_en[i]), .evt_clr(evt_clr[i]),
            .val(gpin[i]), .evt(evt[i])
        );
    end
endmodule

// File: tb/tb_gpin_sync.sv
// tb_gpin_sync: vector table, directed corner sequences and random pins against a window-rule model
module tb_gpin_sync;
    localparam int SS = 2;
    localparam int FL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] pins = '0, rise_en = '0, fall_en = '0, evt_clr = '0;
    logic [31:0] gpin, evt, gpin_p, evt_p;
    logic irq, irq_p;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    gpin_sync #(.SYNC_STAGES(SS), .FILT_PRESC(1), .FILT_LEN(FL)) dut (
        .clk(clk), .rst(rst),
        .gpin0(pins[0]),   .gpin1(pins[1]),   .gpin2(pins[2]),   .gpin3(pins[3]),
        .gpin4(pins[4]),   .gpin5(pins[5]),   .gpin6(pins[6]),   .gpin7(pins[7]),
        .gpin8(pins[8]),   .gpin9(pins[9]),   .gpin10(pins[10]), .gpin11(pins[11]),
        .gpin12(pins[12]), .gpin13(pins[13]), .gpin14(pins[14]), .gpin15(pins[15]),
        .gpin16(pins[16]), .gpin17(pins[17]), .gpin18(pins[18]), .gpin19(pins[19]),
        .gpin20(pins[20]), .gpin21(pins[21]), .gpin22(pins[22]), .gpin23(pins[23]),
        .gpin24(pins[24]), .gpin25(pins[25]), .gpin26(pins[26]), .gpin27(pins[27]),
        .gpin28(pins[28]), .gpin29(pins[29]), .gpin30(pins[30]), .gpin31(pins[31]),
        .rise_en(rise_en), .fall_en(fall_en), .evt_clr(evt_clr),
        .gpin(gpin), .evt(evt), .irq(irq)
    );

    gpin_sync #(.SYNC_STAGES(2), .FILT_PRESC(4), .FILT_LEN(2)) dut_p (
        .clk(clk), .rst(rst),
        .gpin0(pins[0]),   .gpin1(pins[1]),   .gpin2(pins[2]),   .gpin3(pins[3]),
        .gpin4(pins[4]),   .gpin5(pins[5]),   .gpin6(pins[6]),   .gpin7(pins[7]),
        .gpin8(pins[8]),   .gpin9(pins[9]),   .gpin10(pins[10]), .gpin11(pins[11]),
        .gpin12(pins[12]), .gpin13(pins[13]), .gpin14(pins[14]), .gpin15(pins[15]),
        .gpin16(pins[16]), .gpin17(pins[17]), .gpin18(pins[18]), .gpin19(pins[19]),
        .gpin20(pins[20]), .gpin21(pins[21]), .gpin22(pins[22]), .gpin23(pins[23]),
        .gpin24(pins[24]), .gpin25(pins[25]), .gpin26(pins[26]), .gpin27(pins[27]),
        .gpin28(pins[28]), .gpin29(pins[29]), .gpin30(pins[30]), .gpin31(pins[31]),
        .rise_en(rise_en), .fall_en(fall_en), .evt_clr(evt_clr),
        .gpin(gpin_p), .evt(evt_p), .irq(irq_p)
    );

    // Reference: the filtered value flips once the last FL synchronised samples all disagree with it
    logic [31:0] hist [8] = '{default: '0};
    logic [31:0] m_gpin = '0, m_evt = '0;
    logic m_irq = 1'b0;

    always @(posedge clk) begin
        logic [31:0] chg;
        if (rst) begin
            m_gpin = '0;
            m_evt = '0;
            m_irq = 1'b0;
        end else begin
            chg = '1;
            for (int i = 0; i < FL; i++) chg &= hist[SS - 1 + i] ^ m_gpin;
            m_irq = |m_evt;
            m_evt = (chg & ((~m_gpin & rise_en) | (m_gpin & fall_en))) | (m_evt & ~evt_clr);
            m_gpin ^= chg;
        end
        for (int i = 7; i > 0; i--) hist[i] = hist[i - 1];
        hist[0] = rst ? '0 : pins;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            chk("model gpin", gpin, m_gpin);
            chk("model evt", evt, m_evt);
            chk("model irq", {31'b0, irq}, {31'b0, m_irq});
        end
    endtask

    typedef struct packed {
        logic [31:0] pins;
        logic [31:0] rise;
        logic [31:0] clr;
        logic [31:0] gp;
        logic [31:0] ev;
        logic irq;
    } vec_t;
    vec_t tbl [14];

    initial begin
        tbl = '{
            '{32'h1,  32'h21, 32'h0, 32'h0, 32'h0, 1'b0},
            '{32'h1,  32'h21, 32'h0, 32'h0, 32'h0, 1'b0},
            '{32'h1,  32'h21, 32'h0, 32'h0, 32'h0, 1'b0},
            '{32'h1,  32'h21, 32'h0, 32'h0, 32'h0, 1'b0},
            '{32'h1,  32'h21, 32'h0, 32'h1, 32'h1, 1'b0},
            '{32'h1,  32'h21, 32'h0, 32'h1, 32'h1, 1'b1},
            '{32'h1,  32'h21, 32'h1, 32'h1, 32'h0, 1'b1},
            '{32'h1,  32'h21, 32'h0, 32'h1, 32'h0, 1'b0},
            '{32'h21, 32'h21, 32'h0, 32'h1, 32'h0, 1'b0},
            '{32'h21, 32'h21, 32'h0, 32'h1, 32'h0, 1'b0},
            '{32'h1,  32'h21, 32'h0, 32'h1, 32'h0, 1'b0},
            '{32'h1,  32'h21, 32'h0, 32'h1, 32'h0, 1'b0},
            '{32'h1,  32'h21, 32'h0, 32'h1, 32'h0, 1'b0},
            '{32'h1,  32'h21, 32'h0, 32'h1, 32'h0, 1'b0}
        };
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            pins = $urandom;
            step();
            chk("rst gpin", gpin, 32'h0);
            chk("rst evt", evt, 32'h0);
            chk("rst irq", {31'b0, irq}, 32'h0);
        end
        rst = 1'b0;
        pins = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle gpin", gpin, 32'h0);
            chk("idle evt", evt, 32'h0);
        end
        // latency, rise event, clear and bit-5 glitch
        for (int i = 0; i < 14; i++) begin
            pins = tbl[i].pins;
            rise_en = tbl[i].rise;
            evt_clr = tbl[i].clr;
            step();
            chk($sformatf("vec%0d gpin", i), gpin, tbl[i].gp);
            chk($sformatf("vec%0d evt", i), evt, tbl[i].ev);
            chk($sformatf("vec%0d irq", i), {31'b0, irq}, {31'b0, tbl[i].irq});
        end
        evt_clr = '0;
        // fall-only enable on bit 31
        rise_en = '0;
        fall_en = 32'h8000_0000;
        pins = 32'h8000_0001;
        step(10);
        chk("fall rise gpin31", gpin & 32'h8000_0000, 32'h8000_0000);
        chk("fall rise evt31", evt & 32'h8000_0000, 32'h0);
        pins = 32'h1;
        step(10);
        chk("fall gpin31", gpin & 32'h8000_0000, 32'h0);
        chk("fall evt31", evt & 32'h8000_0000, 32'h8000_0000);
        evt_clr = 32'h8000_0000;
        step();
        evt_clr = '0;
        fall_en = '0;
        chk("fall clr evt", evt, 32'h0);
        // set/clear collision on bit 7
        rise_en = 32'h80;
        pins = 32'h81;
        step(6);
        chk("col first evt7", evt & 32'h80, 32'h80);
        pins = 32'h1;
        step(6);
        chk("col low gpin7", gpin & 32'h80, 32'h0);
        chk("col low evt7", evt & 32'h80, 32'h80);
        pins = 32'h81;
        step(4);
        chk("col pre gpin7", gpin & 32'h80, 32'h0);
        evt_clr = 32'h80;
        step();
        evt_clr = '0;
        chk("col set-wins evt7", evt & 32'h80, 32'h80);
        chk("col set gpin7", gpin & 32'h80, 32'h80);
        evt_clr = 32'h80;
        step();
        evt_clr = '0;
        chk("col clr evt", evt, 32'h0);
        chk("col clr irq lag", {31'b0, irq}, 32'h1);
        step();
        chk("col irq drop", {31'b0, irq}, 32'h0);
        // random pins and enables against the model
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                rise_en = $urandom;
                fall_en = $urandom;
            end
            pins ^= $urandom & $urandom & $urandom;
            evt_clr = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            step();
        end
        evt_clr = '0;
        rise_en = '0;
        fall_en = '0;
        // prescaled instance: held change timing
        pins = '0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        pins = 32'h1;
        step(7);
        chk("presc early gpin0", {31'b0, gpin_p[0]}, 32'h0);
        step();
        chk("presc gpin0", {31'b0, gpin_p[0]}, 32'h1);
        pins = 32'h3;
        step(3);
        pins = 32'h1;
        step(15);
        chk("presc pulse gpin1", {31'b0, gpin_p[1]}, 32'h0);
        // reset mid-count must discard the partial count
        pins = '0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        pins = 32'h4;
        step(4);
        chk("presc partial gpin2", {31'b0, gpin_p[2]}, 32'h0);
        rst = 1'b1;
        step(3);
        chk("presc rst gpin", gpin_p, 32'h0);
        rst = 1'b0;
        step(7);
        chk("presc recount early gpin2", {31'b0, gpin_p[2]}, 32'h0);
        step();
        chk("presc recount gpin2", {31'b0, gpin_p[2]}, 32'h1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
